// File: rtl/wb_pkg.sv
// Shared types and defaults for the Wishbone arbiter block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        ABORT  = 2'd3
    } arb_state_e;

    localparam int WB_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/wishbone_if.sv
// Wishbone classic bus bundle. Master drives adr/dat_o/sel/we/stb/cyc;
// the slave drives dat_i/ack/err/rty.
// Latency/backpressure: n/a (wires only; stalls are expressed by withholding ack/err/rty).
interface wishbone_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8
) ();

    logic [ADDR_WIDTH-1:0]   adr;
    logic [DATA_WIDTH-1:0]   dat_o;
    logic [DATA_WIDTH-1:0]   dat_i;
    logic [SELECT_WIDTH-1:0] sel;
    logic                    we;
    logic                    stb;
    logic                    cyc;
    logic                    ack;
    logic                    err;
    logic                    rty;

    modport master (output adr, dat_o, sel, we, stb, cyc, input dat_i, ack, err, rty);
    modport slave  (input adr, dat_o, sel, we, stb, cyc, output dat_i, ack, err, rty);

endinterface

// File: rtl/wb_timeout_ctr.sv
// Bus watchdog: counts stalled cycles and pulses expire_o on the last allowed stall.
// Latency: expire_o is combinational in the cycle the limit is reached.
// Backpressure: none; a response in the same cycle suppresses expire_o.
// Ports: clk/rst, active_i (cyc&stb), response_i (ack|err|rty), clear_i, expire_o.
module wb_timeout_ctr
    import wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = WB_TIMEOUT_DEFAULT,
    parameter int TIMEOUT_WIDTH  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic active_i,
    input  logic response_i,
    input  logic clear_i,
    output logic expire_o
);

    // Counter holds the number of stalls already seen, so the limit-th stall
    // is the one where the count equals TIMEOUT_CYCLES-1.
    localparam logic [TIMEOUT_WIDTH-1:0] LIMIT =
        (TIMEOUT_CYCLES > 0) ? TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [TIMEOUT_WIDTH-1:0] SAT     = '1;
    localparam logic                     ENABLED = (TIMEOUT_CYCLES > 0);

    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || response_i) begin
            cnt_d = '0;
        end else if (active_i && (cnt_q != SAT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = ENABLED && active_i && !response_i && !clear_i && (cnt_q == LIMIT);

endmodule

// File: rtl/wb_arbiter_2.sv
// Two-master round-robin Wishbone arbiter with bus-timeout abort.
// Latency: one cycle from master cyc to wb_out cyc; data/response paths are combinational.
// Backpressure: grant held for the whole cyc; a loser's request waits; hung slaves get err.
// Ports: clk/rst, wb_m0_if/wb_m1_if (masters), wb_out_if (to mux), grant {m1,m0}, timeout_evt.
module wb_arbiter_2
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = WB_TIMEOUT_DEFAULT,
    parameter int TIMEOUT_WIDTH  = 8
) (
    input  logic       clk,
    input  logic       rst,
    wishbone_if.slave  wb_m0_if,
    wishbone_if.slave  wb_m1_if,
    wishbone_if.master wb_out_if,
    output logic [1:0] grant,
    output logic       timeout_evt
);

    arb_state_e state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic [1:0] grant_q, grant_d;
    logic       timeout_evt_q, timeout_evt_d;

    logic m0_req, m1_req;
    logic owner_is_m1, owner_cyc, other_req, in_grant;
    logic out_active, out_resp, expire;

    assign m0_req = wb_m0_if.cyc;
    assign m1_req = wb_m1_if.cyc;

    // In ABORT the owner is remembered only by the held grant vector.
    assign owner_is_m1 = (state_q == GRANT1) || ((state_q == ABORT) && grant_q[1]);
    assign owner_cyc   = owner_is_m1 ? m1_req : m0_req;
    assign other_req   = owner_is_m1 ? m0_req : m1_req;
    assign in_grant    = (state_q == GRANT0) || (state_q == GRANT1);

    assign out_active = wb_out_if.cyc & wb_out_if.stb;
    assign out_resp   = wb_out_if.ack | wb_out_if.err | wb_out_if.rty;

    wb_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
    ) u_timeout (
        .clk        (clk),
        .rst        (rst),
        .active_i   (out_active),
        .response_i (out_resp),
        .clear_i    (!in_grant || !owner_cyc),
        .expire_o   (expire)
    );

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        timeout_evt_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (m0_req && m1_req) begin
                    state_d = last_grant_q ? GRANT0 : GRANT1;
                end else if (m0_req) begin
                    state_d = GRANT0;
                end else if (m1_req) begin
                    state_d = GRANT1;
                end
            end
            GRANT0, GRANT1, ABORT: begin
                if (!owner_cyc) begin
                    // Hand straight over to a waiting master; no idle bubble.
                    last_grant_d = owner_is_m1;
                    if (other_req) begin
                        state_d = owner_is_m1 ? GRANT0 : GRANT1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if ((state_q != ABORT) && expire) begin
                    state_d       = ABORT;
                    timeout_evt_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        unique case (state_d)
            GRANT0:  grant_d = 2'b01;
            GRANT1:  grant_d = 2'b10;
            ABORT:   grant_d = grant_q;
            default: grant_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            grant_q       <= 2'b00;
            timeout_evt_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_q       <= grant_d;
            timeout_evt_q <= timeout_evt_d;
        end
    end

    always_comb begin
        wb_out_if.adr   = {ADDR_WIDTH{1'b0}};
        wb_out_if.dat_o = {DATA_WIDTH{1'b0}};
        wb_out_if.sel   = {SELECT_WIDTH{1'b0}};
        wb_out_if.we    = 1'b0;
        wb_out_if.stb   = 1'b0;
        wb_out_if.cyc   = 1'b0;
        wb_m0_if.dat_i  = {DATA_WIDTH{1'b0}};
        wb_m0_if.ack    = 1'b0;
        wb_m0_if.err    = 1'b0;
        wb_m0_if.rty    = 1'b0;
        wb_m1_if.dat_i  = {DATA_WIDTH{1'b0}};
        wb_m1_if.ack    = 1'b0;
        wb_m1_if.err    = 1'b0;
        wb_m1_if.rty    = 1'b0;
        unique case (state_q)
            GRANT0: begin
                wb_out_if.adr   = wb_m0_if.adr;
                wb_out_if.dat_o = wb_m0_if.dat_o;
                wb_out_if.sel   = wb_m0_if.sel;
                wb_out_if.we    = wb_m0_if.we;
                wb_out_if.stb   = wb_m0_if.stb;
                wb_out_if.cyc   = wb_m0_if.cyc;
                wb_m0_if.dat_i  = wb_out_if.dat_i;
                wb_m0_if.ack    = wb_out_if.ack;
                wb_m0_if.err    = wb_out_if.err;
                wb_m0_if.rty    = wb_out_if.rty;
            end
            GRANT1: begin
                wb_out_if.adr   = wb_m1_if.adr;
                wb_out_if.dat_o = wb_m1_if.dat_o;
                wb_out_if.sel   = wb_m1_if.sel;
                wb_out_if.we    = wb_m1_if.we;
                wb_out_if.stb   = wb_m1_if.stb;
                wb_out_if.cyc   = wb_m1_if.cyc;
                wb_m1_if.dat_i  = wb_out_if.dat_i;
                wb_m1_if.ack    = wb_out_if.ack;
                wb_m1_if.err    = wb_out_if.err;
                wb_m1_if.rty    = wb_out_if.rty;
            end
            ABORT: begin
                // Bus is released; the owner sees err only on the first ABORT cycle.
                if (grant_q[1]) begin
                    wb_m1_if.err = timeout_evt_q;
                end else begin
                    wb_m0_if.err = timeout_evt_q;
                end
            end
            default: ;
        endcase
    end

    assign grant       = grant_q;
    assign timeout_evt = timeout_evt_q;

endmodule

// File: tb/tb_wb_arbiter_2.sv
module tb_wb_arbiter_2;

    localparam int T = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wishbone_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4)) m0_if ();
    wishbone_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4)) m1_if ();
    wishbone_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4)) out_if ();

    logic [1:0] grant;
    logic       timeout_evt;

    wb_arbiter_2 #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (32),
        .SELECT_WIDTH   (4),
        .TIMEOUT_CYCLES (T),
        .TIMEOUT_WIDTH  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_m0_if    (m0_if),
        .wb_m1_if    (m1_if),
        .wb_out_if   (out_if),
        .grant       (grant),
        .timeout_evt (timeout_evt)
    );

    // Bench-driven master and slave signals
    logic        mc[2], ms[2], mwe[2];
    logic [31:0] madr[2], mdo[2];
    logic [3:0]  msel[2];
    logic        s_ack, s_err, s_rty;
    logic [31:0] s_dat;

    assign m0_if.cyc = mc[0];  assign m0_if.stb = ms[0];  assign m0_if.we = mwe[0];
    assign m0_if.adr = madr[0]; assign m0_if.dat_o = mdo[0]; assign m0_if.sel = msel[0];
    assign m1_if.cyc = mc[1];  assign m1_if.stb = ms[1];  assign m1_if.we = mwe[1];
    assign m1_if.adr = madr[1]; assign m1_if.dat_o = mdo[1]; assign m1_if.sel = msel[1];
    assign out_if.ack = s_ack; assign out_if.err = s_err; assign out_if.rty = s_rty;
    assign out_if.dat_i = s_dat;

    // Indexed view of master-side responses
    logic        r_ack[2], r_err[2], r_rty[2];
    logic [31:0] r_dat[2];
    always_comb begin
        r_ack[0] = m0_if.ack; r_err[0] = m0_if.err; r_rty[0] = m0_if.rty; r_dat[0] = m0_if.dat_i;
        r_ack[1] = m1_if.ack; r_err[1] = m1_if.err; r_rty[1] = m1_if.rty; r_dat[1] = m1_if.dat_i;
    end

    int checks = 0;
    int errors = 0;

    task automatic drive_m(input int i, input logic c, input logic s, input logic w,
                           input logic [31:0] a, input logic [31:0] d, input logic [3:0] sl);
        mc[i] = c; ms[i] = s; mwe[i] = w; madr[i] = a; mdo[i] = d; msel[i] = sl;
    endtask

    task automatic clear_all();
        drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat = 32'h0;
    endtask

    // Leaves the bench at posedge+1 with reset released and all inputs idle.
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        clear_all();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", grant); end
        checks++; if (timeout_evt !== 1'b0) begin errors++; $display("FAIL reset_evt: got %b expected 0", timeout_evt); end
        checks++; if ({out_if.cyc, out_if.stb, out_if.we} !== 3'b000) begin errors++; $display("FAIL reset_out_ctl: got %b expected 000", {out_if.cyc, out_if.stb, out_if.we}); end
        checks++; if ({out_if.adr, out_if.dat_o, out_if.sel} !== 68'h0) begin errors++; $display("FAIL reset_out_bus: got %h expected 0", {out_if.adr, out_if.dat_o, out_if.sel}); end
        checks++; if ({m0_if.ack, m0_if.err, m0_if.rty, m1_if.ack, m1_if.err, m1_if.rty} !== 6'b0) begin errors++; $display("FAIL reset_resp: got %b expected 000000", {m0_if.ack, m0_if.err, m0_if.rty, m1_if.ack, m1_if.err, m1_if.rty}); end
        checks++; if ({m0_if.dat_i, m1_if.dat_i} !== 64'h0) begin errors++; $display("FAIL reset_dat_i: got %h expected 0", {m0_if.dat_i, m1_if.dat_i}); end
    endtask

    task automatic test_single_read();
        do_reset();
        drive_m(0, 1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'hF);
        @(negedge clk);
        checks++; if (out_if.cyc !== 1'b0) begin errors++; $display("FAIL read_latency: out cyc %b expected 0", out_if.cyc); end
        step(); @(negedge clk);
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL read_grant: got %b expected 01", grant); end
        checks++; if (out_if.cyc !== 1'b1 || out_if.adr !== 32'h8000_0000) begin errors++; $display("FAIL read_out: cyc %b adr %h expected 1 80000000", out_if.cyc, out_if.adr); end
        checks++; if (m0_if.ack !== 1'b0 || m1_if.ack !== 1'b0) begin errors++; $display("FAIL read_early_ack: m0 %b m1 %b expected 0 0", m0_if.ack, m1_if.ack); end
        step(); s_ack = 1'b1; s_dat = 32'hDEAD_BEEF; @(negedge clk);
        checks++; if (m0_if.ack !== 1'b1 || m0_if.dat_i !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_ack: ack %b dat %h expected 1 deadbeef", m0_if.ack, m0_if.dat_i); end
        checks++; if (m1_if.ack !== 1'b0 || m1_if.dat_i !== 32'h0) begin errors++; $display("FAIL read_m1_quiet: ack %b dat %h expected 0 0", m1_if.ack, m1_if.dat_i); end
        step(); s_ack = 1'b0; drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); @(negedge clk);
        checks++; if (grant !== 2'b01 || out_if.cyc !== 1'b0) begin errors++; $display("FAIL read_release: grant %b cyc %b expected 01 0", grant, out_if.cyc); end
        step(); @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL read_idle: got %b expected 00", grant); end
    endtask

    task automatic test_tie();
        do_reset();
        drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'hF);
        drive_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'hF);
        @(negedge clk);
        step(); s_ack = 1'b1; @(negedge clk);
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL tie1_winner: got %b expected 01", grant); end
        checks++; if (m0_if.ack !== 1'b1 || m1_if.ack !== 1'b0) begin errors++; $display("FAIL tie1_ack: m0 %b m1 %b expected 1 0", m0_if.ack, m1_if.ack); end
        step(); s_ack = 1'b0; drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); @(negedge clk);
        step(); s_ack = 1'b1; @(negedge clk);
        checks++; if (grant !== 2'b10 || out_if.adr !== 32'h0000_2000) begin errors++; $display("FAIL tie1_handover: grant %b adr %h expected 10 00002000", grant, out_if.adr); end
        step(); s_ack = 1'b0; drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); @(negedge clk);
        step(); @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL tie1_idle: got %b expected 00", grant); end
        // Second tie: m1 was served last, so m0 wins; both then drop together.
        step();
        drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_1004, 32'h0, 4'hF);
        drive_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_2004, 32'h0, 4'hF);
        step(); @(negedge clk);
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL tie2_winner: got %b expected 01", grant); end
        step(); clear_all(); @(negedge clk);
        step(); @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL tie2_idle: got %b expected 00", grant); end
        // Third tie: m0 was served last, so m1 wins.
        step();
        drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_1008, 32'h0, 4'hF);
        drive_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_2008, 32'h0, 4'hF);
        step(); @(negedge clk);
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL tie3_winner: got %b expected 10", grant); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive_m(1, 1'b1, 1'b1, 1'b1, 32'h0000_3000, 32'hA5A5_0000, 4'hF);
        step();
        drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_4000, 32'h0, 4'hF);
        for (int b = 0; b < 4; b++) begin
            madr[1] = 32'h0000_3000 + 32'(b * 4);
            mdo[1]  = 32'hA5A5_0000 + 32'(b);
            s_ack   = 1'b1;
            @(negedge clk);
            checks++; if (grant !== 2'b10 || m1_if.ack !== 1'b1 || m0_if.ack !== 1'b0) begin errors++; $display("FAIL burst_beat%0d: grant %b m1ack %b m0ack %b expected 10 1 0", b, grant, m1_if.ack, m0_if.ack); end
            checks++; if (out_if.we !== 1'b1 || out_if.sel !== 4'hF || out_if.adr !== madr[1] || out_if.dat_o !== mdo[1]) begin errors++; $display("FAIL burst_bus%0d: we %b sel %h adr %h dat %h", b, out_if.we, out_if.sel, out_if.adr, out_if.dat_o); end
            step();
        end
        s_ack = 1'b0;
        drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL burst_hold: got %b expected 10", grant); end
        step(); @(negedge clk);
        checks++; if (grant !== 2'b01 || out_if.adr !== 32'h0000_4000) begin errors++; $display("FAIL burst_next: grant %b adr %h expected 01 00004000", grant, out_if.adr); end
    endtask

    task automatic test_timeout();
        do_reset();
        drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'hF);
        @(negedge clk);
        for (int k = 1; k <= T; k++) begin
            step(); @(negedge clk);
            checks++; if (out_if.cyc !== 1'b1 || m0_if.err !== 1'b0 || timeout_evt !== 1'b0) begin errors++; $display("FAIL tmo_stall%0d: cyc %b err %b evt %b expected 1 0 0", k, out_if.cyc, m0_if.err, timeout_evt); end
        end
        step(); @(negedge clk);
        checks++; if (m0_if.err !== 1'b1 || timeout_evt !== 1'b1 || out_if.cyc !== 1'b0 || out_if.stb !== 1'b0) begin errors++; $display("FAIL tmo_abort: err %b evt %b cyc %b stb %b expected 1 1 0 0", m0_if.err, timeout_evt, out_if.cyc, out_if.stb); end
        step(); @(negedge clk);
        checks++; if (m0_if.err !== 1'b0 || timeout_evt !== 1'b0 || out_if.cyc !== 1'b0 || grant !== 2'b01) begin errors++; $display("FAIL tmo_hold: err %b evt %b cyc %b grant %b expected 0 0 0 01", m0_if.err, timeout_evt, out_if.cyc, grant); end
        step(); drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); @(negedge clk);
        step(); @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL tmo_idle: got %b expected 00", grant); end
    endtask

    task automatic test_timeout_edge();
        do_reset();
        drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_6000, 32'h0, 4'hF);
        @(negedge clk);
        for (int k = 1; k < T; k++) begin
            step(); @(negedge clk);
        end
        step(); s_ack = 1'b1; s_dat = 32'h1234_5678; @(negedge clk);
        checks++; if (m0_if.ack !== 1'b1 || m0_if.err !== 1'b0 || m0_if.dat_i !== 32'h1234_5678) begin errors++; $display("FAIL edge_ack: ack %b err %b dat %h expected 1 0 12345678", m0_if.ack, m0_if.err, m0_if.dat_i); end
        step(); s_ack = 1'b0; drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); @(negedge clk);
        checks++; if (timeout_evt !== 1'b0 || m0_if.err !== 1'b0) begin errors++; $display("FAIL edge_no_abort: evt %b err %b expected 0 0", timeout_evt, m0_if.err); end
        step(); @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL edge_idle: got %b expected 00", grant); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_7000, 32'h0, 4'hF);
        step(); @(negedge clk);
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL rmid_grant: got %b expected 10", grant); end
        step(); rst = 1'b1; s_ack = 1'b1;
        drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_8000, 32'h0, 4'hF);
        step(); @(negedge clk);
        checks++; if (grant !== 2'b00 || out_if.cyc !== 1'b0 || out_if.stb !== 1'b0) begin errors++; $display("FAIL rmid_out: grant %b cyc %b stb %b expected 00 0 0", grant, out_if.cyc, out_if.stb); end
        checks++; if ({m0_if.ack, m0_if.err, m1_if.ack, m1_if.err} !== 4'b0) begin errors++; $display("FAIL rmid_resp: got %b expected 0000", {m0_if.ack, m0_if.err, m1_if.ack, m1_if.err}); end
        step(); rst = 1'b0; s_ack = 1'b0;
        step(); @(negedge clk);
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rmid_tie: got %b expected 01", grant); end
    endtask

    // Random traffic against a transaction-level model: owner index, last
    // served master and a count of stalled cycles.
    task automatic test_random();
        int          owner, last, stall, n_owner, n_last, n_stall, s_wait, s_target, pick;
        int          gap[2];
        logic        done[2];
        logic        aborting, err_now, n_abort, n_err, act, resp;
        logic [1:0]  e_grant;
        logic        e_ack, e_err, e_rty;
        logic [31:0] e_dat, e_adr;
        do_reset();
        owner = -1; last = 1; stall = 0; aborting = 1'b0; err_now = 1'b0;
        s_wait = 0; s_target = 0;
        gap[0] = 0; gap[1] = 2; done[0] = 1'b0; done[1] = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (done[i]) begin
                    drive_m(i, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
                    gap[i] = int'($urandom_range(0, 3));
                    done[i] = 1'b0;
                end else if (!mc[i]) begin
                    if (gap[i] == 0) drive_m(i, 1'b1, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(1, 15)));
                    else gap[i]--;
                end
            end
            act = (owner >= 0) ? (!aborting && mc[owner] && ms[owner]) : 1'b0;
            s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat = $urandom;
            if (act) begin
                if (s_wait >= s_target) begin
                    pick = int'($urandom_range(0, 7));
                    if (pick == 0) s_err = 1'b1; else if (pick == 1) s_rty = 1'b1; else s_ack = 1'b1;
                    s_wait = 0;
                end else begin
                    s_wait++;
                end
            end else begin
                s_wait = 0;
                s_target = ($urandom_range(0, 5) == 0) ? 20 : int'($urandom_range(0, 3));
            end
            @(negedge clk);
            e_grant = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
            e_adr   = act ? madr[owner] : 32'h0;
            checks++; if (grant !== e_grant) begin errors++; $display("FAIL rnd_grant @%0d: got %b expected %b", n, grant, e_grant); end
            checks++; if (timeout_evt !== err_now) begin errors++; $display("FAIL rnd_evt @%0d: got %b expected %b", n, timeout_evt, err_now); end
            checks++; if (out_if.cyc !== act || out_if.adr !== e_adr) begin errors++; $display("FAIL rnd_out @%0d: cyc %b adr %h expected %b %h", n, out_if.cyc, out_if.adr, act, e_adr); end
            for (int i = 0; i < 2; i++) begin
                e_ack = (owner == i && !aborting) ? s_ack : 1'b0;
                e_rty = (owner == i && !aborting) ? s_rty : 1'b0;
                e_err = (owner == i) ? (aborting ? err_now : s_err) : 1'b0;
                e_dat = (owner == i && !aborting) ? s_dat : 32'h0;
                checks++; if ({r_ack[i], r_err[i], r_rty[i]} !== {e_ack, e_err, e_rty} || r_dat[i] !== e_dat) begin errors++; $display("FAIL rnd_m%0d @%0d: ack/err/rty %b dat %h expected %b %h", i, n, {r_ack[i], r_err[i], r_rty[i]}, r_dat[i], {e_ack, e_err, e_rty}, e_dat); end
                if (e_ack || e_err || e_rty) done[i] = 1'b1;
            end
            resp = s_ack | s_err | s_rty;
            n_owner = owner; n_last = last; n_stall = stall; n_abort = aborting; n_err = 1'b0;
            if (owner < 0) begin
                if (mc[0] && mc[1]) n_owner = 1 - last;
                else if (mc[0]) n_owner = 0;
                else if (mc[1]) n_owner = 1;
                n_stall = 0;
            end else if (!mc[owner]) begin
                n_last = owner;
                n_owner = mc[1 - owner] ? 1 - owner : -1;
                n_abort = 1'b0;
                n_stall = 0;
            end else if (!aborting) begin
                if (act && !resp) begin
                    n_stall = stall + 1;
                    if (n_stall == T) begin n_abort = 1'b1; n_err = 1'b1; n_stall = 0; end
                end else if (resp) begin
                    n_stall = 0;
                end
            end
            @(posedge clk); #1;
            owner = n_owner; last = n_last; stall = n_stall; aborting = n_abort; err_now = n_err;
        end
        clear_all();
    endtask

    initial begin
        clear_all();
        test_reset();
        test_single_read();
        test_tie();
        test_back_to_back();
        test_timeout();
        test_timeout_edge();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
